// File: rtl/sram_arbiter_pkg.sv
// Shared types for the SRAM arbiter: controller request/result records and arbiter state.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sram_arbiter_pkg;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;

    typedef struct packed {
        logic                   den;
        logic                   oe_n;
        logic                   we_n;
        logic [SRAM_ADDR_W-1:0] address;
        logic [SRAM_DATA_W-1:0] dout;
    } SramRequest_t;

    typedef struct packed {
        logic                   done;
        logic [SRAM_DATA_W-1:0] din;
    } SramResult_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } SramArbState_t;

    // Controller port value whenever no access is in flight
    localparam SramRequest_t SRAM_IDLE_REQUEST = '{
        den:     1'b0,
        oe_n:    1'b1,
        we_n:    1'b1,
        address: '0,
        dout:    '0
    };

endpackage

// File: rtl/sram_arbiter_rr_pick.sv
// Combinational winner picker: client 0 first (unless masked), then round-robin over 1..N-1.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module sram_arb_rr_pick
    import sram_arbiter_pkg::*;
#(
    parameter  int NUM_CLIENTS = 3,
    localparam int IDX_W       = $clog2(NUM_CLIENTS)
) (
    input  logic [NUM_CLIENTS-1:0] req_i,
    input  logic [IDX_W-1:0]       rr_ptr_i,
    input  logic                   client0_mask_i,
    output logic                   valid_o,
    output logic [IDX_W-1:0]       winner_o
);

    logic [IDX_W-1:0] cand;

    // Scan rrPtr+1, rrPtr+2, ... over 1..N-1; the first requester found wins
    always_comb begin
        valid_o  = 1'b0;
        winner_o = '0;
        cand     = '0;
        if (req_i[0] && !client0_mask_i) begin
            valid_o  = 1'b1;
            winner_o = '0;
        end else begin
            for (int k = 1; k < NUM_CLIENTS; k++) begin
                cand = IDX_W'(((int'(rr_ptr_i) - 1 + k) % (NUM_CLIENTS - 1)) + 1);
                if (!valid_o && req_i[cand]) begin
                    valid_o  = 1'b1;
                    winner_o = cand;
                end
            end
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one SRAM controller port: client 0 strict priority, clients 1..N-1 round-robin.
// Latency: request seen in IDLE at cycle t drives the controller at t+1; >=1 idle cycle between accesses.
// Backpressure: grant held until controller done; optional SRAM_ARBITER_STARVE_GUARD_EN bounds client-0 runs.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter  int NUM_CLIENTS = 3
`ifdef SRAM_ARBITER_STARVE_GUARD_EN
    ,
    parameter  int MAX_CONSEC  = 4
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  SramRequest_t           clientReq [NUM_CLIENTS],
    output SramResult_t            clientRes [NUM_CLIENTS],
    output SramRequest_t           sramReq,
    input  SramResult_t            sramRes,
    output logic [NUM_CLIENTS-1:0] grant,
    output logic                   busy
);

    localparam int IDX_W = $clog2(NUM_CLIENTS);

    SramArbState_t          state_q, state_d;
    logic [NUM_CLIENTS-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    SramRequest_t           req_latch_q, req_latch_d;

    logic [NUM_CLIENTS-1:0] req_vec;
    logic                   client0_mask;
    logic                   pick_vld;
    logic [IDX_W-1:0]       pick_idx;

    // Collect the per-client request strobes into one vector
    always_comb begin
        req_vec = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            req_vec[i] = clientReq[i].den;
        end
    end

`ifdef SRAM_ARBITER_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(MAX_CONSEC + 1);

    logic [CNT_W-1:0] cons_q, cons_d;
    logic             lower_req;

    assign lower_req    = |req_vec[NUM_CLIENTS-1:1];
    // After MAX_CONSEC client-0 wins over a waiting lower client, let the lower client through once
    assign client0_mask = (cons_q == CNT_W'(MAX_CONSEC)) && lower_req;

    // Count client-0 wins that made a lower client wait; any lower win clears the run
    always_comb begin
        cons_d = cons_q;
        if (state_q == IDLE && pick_vld) begin
            if (pick_idx == '0) begin
                if (lower_req) begin
                    cons_d = cons_q + 1'b1;
                end
            end else begin
                cons_d = '0;
            end
        end
    end

    // Starvation counter register
    always_ff @(posedge clk) begin
        if (!rst) begin
            cons_q <= '0;
        end else begin
            cons_q <= cons_d;
        end
    end
`else
    assign client0_mask = 1'b0;
`endif

    sram_arb_rr_pick #(
        .NUM_CLIENTS(NUM_CLIENTS)
    ) u_pick (
        .req_i         (req_vec),
        .rr_ptr_i      (rr_ptr_q),
        .client0_mask_i(client0_mask),
        .valid_o       (pick_vld),
        .winner_o      (pick_idx)
    );

    // State register; reset abandons any access in flight
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= IDX_W'(NUM_CLIENTS - 1);
            req_latch_q <= SRAM_IDLE_REQUEST;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            req_latch_q <= req_latch_d;
        end
    end

    // Next state: arbitrate and latch in IDLE, wait for controller done in BUSY
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        req_latch_d = req_latch_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d           = BUSY;
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    req_latch_d       = clientReq[pick_idx];
                    // Client 0 wins do not disturb the lower clients' rotation
                    if (pick_idx != '0) begin
                        rr_ptr_d = pick_idx;
                    end
                end
            end
            BUSY: begin
                if (sramRes.done) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Outputs: latched request to the controller, data broadcast, done only to the owner
    always_comb begin
        sramReq = SRAM_IDLE_REQUEST;
        busy    = 1'b0;
        if (state_q == BUSY) begin
            sramReq = req_latch_q;
            busy    = 1'b1;
        end
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            clientRes[i].din  = sramRes.din;
            clientRes[i].done = (state_q == BUSY) && grant_q[i] && sramRes.done;
        end
    end

    assign grant = grant_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios with literal expectations plus
// a randomized phase compared every cycle against a transaction-level reference model.
// The starve-guard expectations follow SRAM_ARBITER_STARVE_GUARD_EN when it is defined.
module tb_sram_arbiter;
    import sram_arbiter_pkg::*;

    localparam int NC   = 3;
    localparam int MAXC = 4;

    logic          clk;
    logic          rst;
    SramRequest_t  clientReq [NC];
    SramResult_t   clientRes [NC];
    SramRequest_t  sramReq;
    SramResult_t   sramRes;
    logic [NC-1:0] grant;
    logic          busy;

    int total = 0;
    int bad   = 0;

    // reference model state (owner = -1 means no access in flight)
    bit           m_valid = 0;
    int           m_owner;
    int           m_rr;
    int           m_cnt;
    SramRequest_t m_latch;

    int dut_seq[$];
    int mdl_seq[$];

    sram_arbiter #(.NUM_CLIENTS(NC)) dut (
        .clk      (clk),
        .rst      (rst),
        .clientReq(clientReq),
        .clientRes(clientRes),
        .sramReq  (sramReq),
        .sramRes  (sramRes),
        .grant    (grant),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic SramRequest_t idle_req();
        SramRequest_t r;
        r.den = 1'b0; r.oe_n = 1'b1; r.we_n = 1'b1; r.address = '0; r.dout = '0;
        return r;
    endfunction

    // Priority pick: client 0 unless excluded, then the next requester after rr among 1..NC-1
    function automatic int model_pick(logic [NC-1:0] den, int rr, bit excl0);
        int c;
        if (den[0] && !excl0) return 0;
        c = rr;
        for (int k = 0; k < NC - 1; k++) begin
            c = (c >= NC - 1) ? 1 : c + 1;
            if (den[c]) return c;
        end
        return -1;
    endfunction

    function automatic int gidx(logic [NC-1:0] g);
        for (int i = 0; i < NC; i++) if (g[i]) return i;
        return -1;
    endfunction

    // Compare DUT outputs with the model, then advance the model across the coming edge
    always @(negedge clk) begin
        logic [NC-1:0] den;
        logic [NC-1:0] lower;
        bit            excl0;
        int            w;
        if (m_valid) begin
            chk("grant", 64'(grant), (m_owner < 0) ? 64'd0 : (64'd1 << m_owner));
            chk("busy", 64'(busy), 64'(m_owner >= 0));
            chk("sramReq", 64'(sramReq), 64'((m_owner >= 0) ? m_latch : idle_req()));
            for (int i = 0; i < NC; i++) begin
                chk("res_done", 64'(clientRes[i].done), 64'((m_owner == i) && sramRes.done));
                chk("res_din", 64'(clientRes[i].din), 64'(sramRes.din));
            end
        end
        for (int i = 0; i < NC; i++) den[i] = clientReq[i].den;
        lower    = den;
        lower[0] = 1'b0;
        if (!rst) begin
            m_valid = 1;
            m_owner = -1;
            m_rr    = NC - 1;
            m_cnt   = 0;
            m_latch = idle_req();
        end else if (m_valid) begin
            if (m_owner < 0) begin
`ifdef SRAM_ARBITER_STARVE_GUARD_EN
                excl0 = (m_cnt == MAXC) && (lower != 0);
`else
                excl0 = 0;
`endif
                w = model_pick(den, m_rr, excl0);
                if (w >= 0) begin
                    m_owner = w;
                    m_latch = clientReq[w];
                    if (w != 0) begin
                        m_rr  = w;
                        m_cnt = 0;
                    end else if (lower != 0) begin
                        m_cnt = m_cnt + 1;
                    end
                end
            end else if (sramRes.done) begin
                m_owner = -1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < NC; i++) clientReq[i] = idle_req();
    endtask

    task automatic req(int c, logic [17:0] addr, logic we);
        clientReq[c].den     = 1'b1;
        clientReq[c].oe_n    = we;
        clientReq[c].we_n    = ~we;
        clientReq[c].address = addr;
        clientReq[c].dout    = 16'(16'hA000 + c);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    // Serve each access in one busy cycle and log who owned it
    task automatic collect(int n_acc);
        int guard = 0;
        dut_seq.delete();
        mdl_seq.delete();
        while (dut_seq.size() < n_acc && guard < 200) begin
            tick();
            if (busy) begin
                dut_seq.push_back(gidx(grant));
                mdl_seq.push_back(m_owner);
                sramRes.done = 1'b1;
            end else begin
                sramRes.done = 1'b0;
            end
            guard++;
        end
        chk("collect_count", 64'(dut_seq.size()), 64'(n_acc));
    endtask

    task automatic chk_seq(string name, int exp[$]);
        for (int i = 0; i < exp.size(); i++) begin
            chk(name, 64'(dut_seq[i]), 64'(exp[i]));
            chk({name, "_model"}, 64'(mdl_seq[i]), 64'(exp[i]));
        end
    endtask

    task automatic drain();
        clear_reqs();
        tick();
        sramRes.done = 1'b0;
        tick();
    endtask

    initial begin
        int exp_q[$];
        rst          = 1'b0;
        sramRes.done = 1'b0;
        sramRes.din  = 16'h5A5A;
        clear_reqs();

        // reset held with everybody requesting
        for (int i = 0; i < NC; i++) req(i, 18'(i), 1'b0);
        tick();
        tick();
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_den", 64'(sramReq.den), 64'd0);
        rst = 1'b1;
        tick();
        chk("post_rst_grant", 64'(grant), 64'd1);
        clear_reqs();
        sramRes.done = 1'b1;
        tick();
        sramRes.done = 1'b0;
        tick();

        // client 1 alone writes 0x100, done after 3 busy cycles
        req(1, 18'h100, 1'b1);
        tick();
        chk("c1_addr", 64'(sramReq.address), 64'h100);
        chk("c1_den", 64'(sramReq.den), 64'd1);
        chk("c1_we_n", 64'(sramReq.we_n), 64'd0);
        chk("c1_grant", 64'(grant), 64'd2);
        clear_reqs();
        tick();
        tick();
        sramRes.done = 1'b1;
        #1;
        chk("c1_done", 64'(clientRes[1].done), 64'd1);
        chk("c2_no_done", 64'(clientRes[2].done), 64'd0);
        tick();
        sramRes.done = 1'b0;
        #1;
        chk("c1_done_pulse", 64'(clientRes[1].done), 64'd0);
        chk("c1_grant_clr", 64'(grant), 64'd0);
        tick();

        // all three requesting: client 0 only; then 1 and 2 alternate
        do_reset();
        for (int i = 0; i < NC; i++) req(i, 18'(16 * i), 1'b0);
        collect(3);
        exp_q = '{0, 0, 0};
        chk_seq("prio_seq", exp_q);
        clientReq[0].den = 1'b0;
        collect(4);
        exp_q = '{1, 2, 1, 2};
        chk_seq("rr_seq", exp_q);
        drain();

        // requester changes address mid-access
        req(2, 18'h200, 1'b0);
        tick();
        chk("c2_addr0", 64'(sramReq.address), 64'h200);
        clientReq[2].address = 18'h204;
        tick();
        chk("c2_addr1", 64'(sramReq.address), 64'h200);
        tick();
        chk("c2_addr2", 64'(sramReq.address), 64'h200);
        clientReq[2].den = 1'b0;
        sramRes.done = 1'b1;
        tick();
        sramRes.done = 1'b0;
        chk("c2_idle", 64'(busy), 64'd0);
        tick();

        // clients 0 and 1 always requesting
        do_reset();
        req(0, 18'h10, 1'b0);
        req(1, 18'h11, 1'b1);
        collect(10);
`ifdef SRAM_ARBITER_STARVE_GUARD_EN
        exp_q = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
`else
        exp_q = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`endif
        chk_seq("guard_seq", exp_q);
        drain();

        // reset during an access, then a stale done
        req(1, 18'h300, 1'b1);
        tick();
        chk("mid_busy", 64'(busy), 64'd1);
        rst = 1'b0;
        tick();
        chk("mid_rst_den", 64'(sramReq.den), 64'd0);
        chk("mid_rst_grant", 64'(grant), 64'd0);
        rst = 1'b1;
        clear_reqs();
        sramRes.done = 1'b1;
        #1;
        chk("stale_done", 64'(clientRes[1].done), 64'd0);
        tick();
        sramRes.done = 1'b0;
        tick();

        // randomized traffic, checked every cycle by the model
        for (int n = 0; n < 4000; n++) begin
            rst = ($urandom_range(0, 99) != 0);
            for (int i = 0; i < NC; i++) begin
                clientReq[i].den     = ($urandom_range(0, 2) == 0);
                clientReq[i].oe_n    = 1'($urandom);
                clientReq[i].we_n    = 1'($urandom);
                clientReq[i].address = 18'($urandom);
                clientReq[i].dout    = 16'($urandom);
            end
            sramRes.done = ($urandom_range(0, 2) == 0);
            sramRes.din  = 16'($urandom);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single SRAM controller port between several requesters. Client 0 is the display scanout reader. Clients 1..N-1 are render writers such as the font shape renderer.
- Sits between the requesters' SramRequest_t/SramResult_t pairs and the SRAM controller.
- Grants one access at a time and holds the grant until the controller reports done.
- Client 0 has fixed top priority. Lower clients share round-robin.

Parameters:
- NUM_CLIENTS, 3, number of requesters (2..8); index 0 is the high-priority client.
- MAX_CONSEC, 4, consecutive client-0 grants allowed while a lower client waits. Used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-low reset
- clientReq  in  NUM_CLIENTS x SramRequest_t  per-client request; den=1 means requesting
- clientRes  out  NUM_CLIENTS x SramResult_t  per-client result
- sramReq  out  SramRequest_t  request to the SRAM controller
- sramRes  in  SramResult_t  result from the SRAM controller
- grant  out  NUM_CLIENTS  one-hot current owner; all zero when idle
- busy  out  1  high while an access is in flight

Behaviour:
- Reset: one clock, synchronous, active-low. While rst=0 at a clk edge:
  - state<=IDLE, grant<=0, rrPtr<=NUM_CLIENTS-1, consecutive counter<=0.
  - sramReq={den=0, oe_n=1, we_n=1, address=0, dout=0}.
  - All clientRes.done=0.
- Reset mid-access: the access is abandoned, and sramReq.den is 0 from the first cycle after the reset edge.
- States: IDLE, BUSY.
- IDLE:
  - sramReq is the idle constant; busy=0.
  - If any clientReq[i].den=1, select a winner, latch clientReq[winner] into reqLatch, set grant to onehot(winner), then go to BUSY on the next edge.
  - Otherwise stay in IDLE.
- Winner selection:
  - Client 0 wins if its den=1.
  - Otherwise the first client with den=1 in the order rrPtr+1, rrPtr+2, ... over indices 1..NUM_CLIENTS-1, with wrap-around.
  - rrPtr updates to the winner only when the winner is non-zero.
- BUSY:
  - sramReq=reqLatch (latched, so requester changes mid-access are ignored); busy=1.
  - On sramRes.done=1: clientRes[owner].done=1 in that same cycle (combinational pass-through), then IDLE, grant cleared.
  - The access always completes, even if the owner drops den.
- clientRes fan-out:
  - Data fields of sramRes are broadcast to every client.
  - done reaches only the owner while BUSY; all other clients, and all clients in IDLE, see done=0.
- Latency:
  - Request seen in IDLE at cycle t, so sramReq.den=1 at t+1.
  - Minimum 1 idle turnaround cycle between accesses. A continuously requesting client gets at most one access every 2+ cycles.
- Simultaneous requests from all clients: client 0 first. Lower clients are then served in rotation 1,2,...,1 as client 0 stays idle.
- sramRes.done while IDLE is ignored.

Optional Feature:
- Macro: SRAM_ARBITER_STARVE_GUARD_EN.
- With the macro:
  - An arbitration where client 0 wins while any lower client has den=1 increments the counter.
  - An arbitration won by a lower client clears it.
  - When the counter equals MAX_CONSEC, client 0 is excluded from the next arbitration if a lower client requests; the counter is then cleared.
- Without the macro: strict priority; counter and MAX_CONSEC logic absent.

Decomposition:
- Shared package (DataType.sv) takes:
  - SramArbState_t enum {IDLE, BUSY}
  - SRAM_IDLE_REQUEST constant (den=0, oe_n=1, we_n=1, address=0, dout=0)
  - SramRequest_t and SramResult_t stay as they are.
- Sub-module sram_arb_rr_pick: combinational round-robin picker.
  - Inputs: request vector, rrPtr, client0Mask.
  - Outputs: valid, winner index.

Test Plan:
- Reset: rst=0 for 2 cycles while all clients request → grant=0, busy=0, sramReq.den=0. After release, client 0 is granted one cycle later.
- Client 1 alone writes address 0x100 → sramReq.address=0x100 at t+1. Controller done after 3 cycles → clientRes[1].done pulses one cycle, clientRes[2].done stays 0, grant returns to 0.
- Clients 0,1,2 all request continuously → grant sequence 0,0,0,… (starve guard off). Drop client 0 → sequence 1,2,1,2.
- Client 2 changes address 0x200→0x204 mid-access → sramReq.address stays 0x200 until done.
- With SRAM_ARBITER_STARVE_GUARD_EN, MAX_CONSEC=4, clients 0 and 1 always requesting → grants 0,0,0,0,1,0,0,0,0,1.
- Assert rst=0 during BUSY → sramReq.den=0 and grant=0 on the next cycle. A stale done afterwards produces no clientRes.done.
